// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver.
// Holds the FSM state encoding, the parity modes and the sample-point helper.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Mid-bit sample position inside a CLK_DIV-long bit period.
    function automatic int sample_point(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter for the UART receiver.
// Counts 1..CLK_DIV while running and flags the mid-bit sample cycle.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 5208
) (
    input  logic clk,
    input  logic n_rst,
    input  logic run_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [15:0] TOP  = 16'(CLK_DIV);
    localparam logic [15:0] HALF = 16'(sample_point(CLK_DIV));

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: load 1 on frame start, idle at 0, otherwise wrap at TOP.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 16'd1;
        end else if (!run_i) begin
            cnt_d = 16'd0;
        end else if (cnt_q == TOP) begin
            cnt_d = 16'd1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = run_i && (cnt_q == HALF);

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with optional parity, 1/2 stop bits and a held output word.
// Frames finishing while the word is still unread are dropped with a pulse.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 5208,
    parameter int DATA_W  = 8,
    parameter int PARITY  = 0,
    parameter int STOP_W  = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    localparam logic [3:0] LAST_BIT  = 4'(DATA_W - 1);
    localparam logic       LAST_STOP = 1'(STOP_W - 1);
    localparam logic       PAR_INV   = (PARITY == PAR_ODD);

    logic              s1_q;
    logic              rxs_q;
    logic [1:0]        vld_q;
    logic              armed_q;
    state_e            state_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        bit_q;
    logic              stop_q;
    logic              ferr_q;
    logic              perr_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              frame_err_q;
    logic              parity_err_q;
    logic              overrun_q;

    logic tick;
    logic start;
    logic done;

    // Two-flop synchronizer; armed only once a genuine high has been seen.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_q    <= 1'b1;
            rxs_q   <= 1'b1;
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            s1_q  <= rxd;
            rxs_q <= s1_q;
            vld_q <= {vld_q[0], 1'b1};
            if (vld_q[1] && rxs_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign start = (state_q == S_IDLE) && armed_q && !rxs_q;
    assign done  = (state_q == S_STOP) && tick && (stop_q == LAST_STOP);

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .n_rst   (n_rst),
        .run_i   (state_q != S_IDLE),
        .clear_i (start),
        .tick_o  (tick)
    );

    // Frame FSM: start validation, data shift, parity and stop checks.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            bit_q   <= 4'd0;
            stop_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_START;
                        bit_q   <= 4'd0;
                        stop_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                        perr_q  <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        state_q <= rxs_q ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        data_q <= {rxs_q, data_q[DATA_W-1:1]};
                        if (bit_q == LAST_BIT) begin
                            bit_q   <= 4'd0;
                            state_q <= (PARITY != PAR_NONE) ? S_PAR : S_STOP;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                end
                S_PAR: begin
                    if (tick) begin
                        perr_q  <= rxs_q ^ (^data_q) ^ PAR_INV;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        ferr_q <= ferr_q | ~rxs_q;
                        if (stop_q == LAST_STOP) begin
                            state_q <= S_IDLE;
                        end else begin
                            stop_q <= ~stop_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Output holding register with valid/ready handshake and overrun pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (done) begin
                if (rx_valid_q && !rx_ready) begin
                    overrun_q <= 1'b1;
                end else begin
                    rx_data_q    <= data_q;
                    frame_err_q  <= ferr_q | ~rxs_q;
                    parity_err_q <= perr_q;
                    rx_valid_q   <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext at CLK_DIV=16.
// Three instances: 8N1, 8E1 and 8N2, each with its own line and ready.
module tb_uart_rx_ext;

    localparam int DIV = 16;

    logic clk;
    logic n_rst;
    logic rxd0, rxd1, rxd2;
    logic rdy0, rdy1, rdy2;
    logic [7:0] d0, d1, d2;
    logic v0, v1, v2;
    logic fe0, fe1, fe2;
    logic pe0, pe1, pe2;
    logic ov0, ov1, ov2;
    logic busy0, busy1, busy2;

    int n_chk;
    int n_fail;

    uart_rx_ext #(.CLK_DIV(DIV), .DATA_W(8), .PARITY(0), .STOP_W(1)) u0 (
        .clk(clk), .n_rst(n_rst), .rxd(rxd0), .rx_data(d0), .rx_valid(v0),
        .rx_ready(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0),
        .busy(busy0)
    );

    uart_rx_ext #(.CLK_DIV(DIV), .DATA_W(8), .PARITY(1), .STOP_W(1)) u1 (
        .clk(clk), .n_rst(n_rst), .rxd(rxd1), .rx_data(d1), .rx_valid(v1),
        .rx_ready(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1),
        .busy(busy1)
    );

    uart_rx_ext #(.CLK_DIV(DIV), .DATA_W(8), .PARITY(0), .STOP_W(2)) u2 (
        .clk(clk), .n_rst(n_rst), .rxd(rxd2), .rx_data(d2), .rx_valid(v2),
        .rx_ready(rdy2), .frame_err(fe2), .parity_err(pe2), .overrun(ov2),
        .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input int ch, input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            case (ch)
                0: rxd0 = bits[i];
                1: rxd1 = bits[i];
                default: rxd2 = bits[i];
            endcase
            repeat (DIV) @(negedge clk);
        end
        case (ch)
            0: rxd0 = 1'b1;
            1: rxd1 = 1'b1;
            default: rxd2 = 1'b1;
        endcase
    endtask

    // Observes one instance for n cycles; indices count posedges since call.
    task automatic watch(input int ch, input int n,
                         output int rise, output int vcnt,
                         output int orise, output int ocnt, output int bcnt,
                         output logic [7:0] d, output logic fe,
                         output logic pe);
        logic v, o, b, f, p;
        logic [7:0] dd;
        rise = -1; vcnt = 0; orise = -1; ocnt = 0; bcnt = 0;
        d = 8'h00; fe = 1'b0; pe = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            case (ch)
                0: begin v = v0; o = ov0; b = busy0; dd = d0; f = fe0; p = pe0; end
                1: begin v = v1; o = ov1; b = busy1; dd = d1; f = fe1; p = pe1; end
                default: begin
                    v = v2; o = ov2; b = busy2; dd = d2; f = fe2; p = pe2;
                end
            endcase
            if (v) vcnt++;
            if (v && rise < 0) begin
                rise = i; d = dd; fe = f; pe = p;
            end
            if (o) begin
                ocnt++;
                if (orise < 0) orise = i;
            end
            if (b) bcnt++;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        rxd0 = 1'b1; rxd1 = 1'b1; rxd2 = 1'b1;
        rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({v0, v1, v2} !== 3'b000) begin
            n_fail++; $display("FAIL rst_valid: got %b want 000", {v0, v1, v2});
        end
        n_chk++;
        if ({d0, d1, d2} !== 24'h0) begin
            n_fail++; $display("FAIL rst_data: got %h want 000000", {d0, d1, d2});
        end
        n_chk++;
        if ({fe0, fe1, fe2, pe0, pe1, pe2} !== 6'b0) begin
            n_fail++; $display("FAIL rst_err: got %b want 000000",
                               {fe0, fe1, fe2, pe0, pe1, pe2});
        end
        n_chk++;
        if ({ov0, ov1, ov2, busy0, busy1, busy2} !== 6'b0) begin
            n_fail++; $display("FAIL rst_ov_busy: got %b want 000000",
                               {ov0, ov1, ov2, busy0, busy1, busy2});
        end
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_8n1();
        int rise, vcnt, orise, ocnt, bcnt;
        logic [7:0] d;
        logic fe, pe;
        fork
            send(0, 32'({1'b1, 8'hA5, 1'b0}), 10);
            watch(0, 180, rise, vcnt, orise, ocnt, bcnt, d, fe, pe);
        join
        n_chk++;
        if (rise !== 155) begin
            n_fail++; $display("FAIL 8n1_rise: got %0d want 155", rise);
        end
        n_chk++;
        if (vcnt !== 1) begin
            n_fail++; $display("FAIL 8n1_pulse: got %0d want 1", vcnt);
        end
        n_chk++;
        if (d !== 8'hA5) begin
            n_fail++; $display("FAIL 8n1_data: got %h want a5", d);
        end
        n_chk++;
        if ({fe, pe, ocnt[0]} !== 3'b000) begin
            n_fail++; $display("FAIL 8n1_err: got %b want 000", {fe, pe, ocnt[0]});
        end
        n_chk++;
        if (busy0 !== 1'b0) begin
            n_fail++; $display("FAIL 8n1_idle: got %b want 0", busy0);
        end
    endtask

    task automatic test_parity();
        int rise, vcnt, orise, ocnt, bcnt;
        logic [7:0] d;
        logic fe, pe;
        fork
            send(1, 32'({1'b1, 1'b1, 8'h3C, 1'b0}), 11);
            watch(1, 190, rise, vcnt, orise, ocnt, bcnt, d, fe, pe);
        join
        n_chk++;
        if (rise !== 171) begin
            n_fail++; $display("FAIL par_rise: got %0d want 171", rise);
        end
        n_chk++;
        if (d !== 8'h3C) begin
            n_fail++; $display("FAIL par_data: got %h want 3c", d);
        end
        n_chk++;
        if ({pe, fe} !== 2'b10) begin
            n_fail++; $display("FAIL par_bad: got %b want 10", {pe, fe});
        end
        fork
            send(1, 32'({1'b1, 1'b0, 8'h3C, 1'b0}), 11);
            watch(1, 190, rise, vcnt, orise, ocnt, bcnt, d, fe, pe);
        join
        n_chk++;
        if ({pe, fe, d} !== {2'b00, 8'h3C}) begin
            n_fail++; $display("FAIL par_good: got %b_%h want 00_3c", {pe, fe}, d);
        end
    endtask

    task automatic test_frame_err();
        int rise, vcnt, orise, ocnt, bcnt;
        logic [7:0] d;
        logic fe, pe;
        fork
            send(0, 32'({1'b0, 8'h55, 1'b0}), 10);
            watch(0, 200, rise, vcnt, orise, ocnt, bcnt, d, fe, pe);
        join
        n_chk++;
        if ({rise, vcnt} !== {32'd155, 32'd1}) begin
            n_fail++; $display("FAIL ferr_timing: got %0d/%0d want 155/1", rise, vcnt);
        end
        n_chk++;
        if ({fe, d} !== {1'b1, 8'h55}) begin
            n_fail++; $display("FAIL ferr_stop1: got %b_%h want 1_55", fe, d);
        end
        fork
            send(2, 32'({1'b0, 1'b1, 8'h55, 1'b0}), 11);
            watch(2, 200, rise, vcnt, orise, ocnt, bcnt, d, fe, pe);
        join
        n_chk++;
        if ({rise, vcnt} !== {32'd171, 32'd1}) begin
            n_fail++; $display("FAIL ferr2_timing: got %0d/%0d want 171/1", rise, vcnt);
        end
        n_chk++;
        if ({fe, pe, d} !== {2'b10, 8'h55}) begin
            n_fail++; $display("FAIL ferr_stop2: got %b_%h want 10_55", {fe, pe}, d);
        end
        fork
            send(2, 32'({1'b1, 1'b1, 8'hC3, 1'b0}), 11);
            watch(2, 190, rise, vcnt, orise, ocnt, bcnt, d, fe, pe);
        join
        n_chk++;
        if ({fe, d} !== {1'b0, 8'hC3}) begin
            n_fail++; $display("FAIL ferr2_clean: got %b_%h want 0_c3", fe, d);
        end
    endtask

    task automatic test_glitch();
        int rise, vcnt, orise, ocnt, bcnt;
        logic [7:0] d;
        logic fe, pe;
        fork
            begin
                rxd0 = 1'b0;
                repeat (5) @(negedge clk);
                rxd0 = 1'b1;
            end
            watch(0, 40, rise, vcnt, orise, ocnt, bcnt, d, fe, pe);
        join
        n_chk++;
        if (vcnt !== 0) begin
            n_fail++; $display("FAIL glitch_valid: got %0d want 0", vcnt);
        end
        n_chk++;
        if (bcnt !== 8) begin
            n_fail++; $display("FAIL glitch_busy: got %0d want 8", bcnt);
        end
        n_chk++;
        if (busy0 !== 1'b0) begin
            n_fail++; $display("FAIL glitch_idle: got %b want 0", busy0);
        end
    endtask

    task automatic test_back_to_back();
        int rise, vcnt, orise, ocnt, bcnt;
        logic [7:0] d;
        logic fe, pe;
        rdy0 = 1'b0;
        fork
            send(0, 32'({1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}), 20);
            watch(0, 340, rise, vcnt, orise, ocnt, bcnt, d, fe, pe);
        join
        n_chk++;
        if ({rise, d} !== {32'd155, 8'h11}) begin
            n_fail++; $display("FAIL b2b_first: got %0d/%h want 155/11", rise, d);
        end
        n_chk++;
        if ({orise, ocnt} !== {32'd315, 32'd1}) begin
            n_fail++; $display("FAIL b2b_overrun: got %0d/%0d want 315/1", orise, ocnt);
        end
        n_chk++;
        if ({v0, d0} !== {1'b1, 8'h11}) begin
            n_fail++; $display("FAIL b2b_held: got %b_%h want 1_11", v0, d0);
        end
        rdy0 = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({v0, d0} !== {1'b0, 8'h11}) begin
            n_fail++; $display("FAIL b2b_handshake: got %b_%h want 0_11", v0, d0);
        end
    endtask

    task automatic test_reset_mid();
        int rise, vcnt, orise, ocnt, bcnt;
        logic [7:0] d;
        logic fe, pe;
        rxd0 = 1'b0;
        repeat (40) @(negedge clk);
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({v0, d0, fe0, pe0, ov0, busy0} !== 13'b0) begin
            n_fail++; $display("FAIL rmid_outputs: got %b_%h_%b want 0_00_0000",
                               v0, d0, {fe0, pe0, ov0, busy0});
        end
        n_rst = 1'b1;
        watch(0, 40, rise, vcnt, orise, ocnt, bcnt, d, fe, pe);
        n_chk++;
        if ({vcnt, bcnt} !== {32'd0, 32'd0}) begin
            n_fail++; $display("FAIL rmid_no_start: got %0d/%0d want 0/0", vcnt, bcnt);
        end
        rxd0 = 1'b1;
        repeat (20) @(negedge clk);
        fork
            send(0, 32'({1'b1, 8'h3C, 1'b0}), 10);
            watch(0, 180, rise, vcnt, orise, ocnt, bcnt, d, fe, pe);
        join
        n_chk++;
        if ({rise, d, fe} !== {32'd155, 8'h3C, 1'b0}) begin
            n_fail++; $display("FAIL rmid_new_frame: got %0d/%h/%b want 155/3c/0",
                               rise, d, fe);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5208, clock cycles per bit (legal range 4..65535).
REQ-002 SHALL have parameter DATA_W, default 8, data bits per frame (legal range 5..9).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_W, default 1, stop bits checked (1 or 2).
REQ-005 SHALL have port clk, input, 1 bit, single clock; all flops on rising edge.
REQ-006 SHALL have port n_rst, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port rxd, input, 1 bit, asynchronous serial line, idle high.
REQ-008 SHALL have port rx_data, output, DATA_W bits, received word, LSB first on line.
REQ-009 SHALL have port rx_valid, output, 1 bit, rx_data and error flags valid.
REQ-010 SHALL have port rx_ready, input, 1 bit, consumer accepts word.
REQ-011 SHALL have port frame_err, output, 1 bit, a stop bit sampled low; qualified by rx_valid.
REQ-012 SHALL have port parity_err, output, 1 bit, parity mismatch; qualified by rx_valid, always 0 when PARITY=0.
REQ-013 SHALL have port overrun, output, 1 bit, one-cycle pulse: frame dropped.
REQ-014 SHALL have port busy, output, 1 bit, high whenever FSM not in IDLE.

Function
REQ-015 SHALL pass rxd through a 2-flop synchronizer (reset value 1); all logic uses the synchronized signal rxs.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PAR, STOP.
REQ-017 SHALL run the bit counter only outside IDLE: count 1..CLK_DIV, wrap to 1, sample tick when count == CLK_DIV/2 (integer division).
REQ-018 IDLE -> START SHALL occur on the cycle rxs is first sampled 0; the counter starts at 1 on that cycle.
REQ-019 START: at sample tick, rxs=1 SHALL return to IDLE (false start, no output change); rxs=0 SHALL go to DATA.
REQ-020 DATA SHALL shift in DATA_W samples LSB first, then go to PAR if PARITY!=0, else to STOP.
REQ-021 PAR SHALL compare the sample with the XOR of data bits (even: equal; odd: inverted) and record the mismatch.
REQ-022 STOP SHALL sample STOP_W bits, OR any low sample into the frame error, and go to IDLE at the last stop sample tick (half-bit early, for resync).
REQ-023 rx_valid SHALL rise exactly 1 clk after the last stop sample tick, with rx_data, frame_err and parity_err updated on that same edge.
REQ-024 rx_valid, rx_data and the error flags SHALL hold stable until a cycle with rx_valid & rx_ready; rx_valid SHALL fall on the next edge.
REQ-025 A frame completing while rx_valid=1 and rx_ready=0 SHALL be discarded, the held word retained, and overrun pulsed for 1 clk.
REQ-026 A frame completing in the same cycle as a handshake SHALL be loaded, with rx_valid remaining 1 and no overrun.
REQ-027 Word reception SHALL continue into a new frame while rx_valid is pending; back-to-back frames with no idle gap SHALL be received.

Reset
REQ-028 On n_rst low: state IDLE, counters 0, synchronizer 1, rx_data 0, rx_valid 0, frame_err 0, parity_err 0, overrun 0, busy 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait for a fresh falling edge, with no spurious start from a line already low before release (rx restarts only after rxs is seen high).

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state encoding, the parity mode constants (PAR_NONE/EVEN/ODD) and the sample-point function CLK_DIV/2.
REQ-031 Sub-module uart_baud_tick SHALL contain the bit counter and sample-tick generation, parametrised by CLK_DIV, with run/clear inputs.

Verification (bench CLK_DIV=16 unless stated)
REQ-032 8N1 frame 0xA5, rx_ready=1 -> rx_valid 1-cycle pulse, rx_data=0xA5, no errors, valid 1 clk after stop mid-sample.
REQ-033 PARITY=1, 0x3C sent with parity bit 1 -> rx_data=0x3C, parity_err=1; with parity bit 0 -> parity_err=0.
REQ-034 Stop bit driven low on 0x55 -> rx_valid with frame_err=1; STOP_W=2 with only the second stop bit low -> frame_err=1.
REQ-035 Low glitch of 5 clk on idle line -> no rx_valid, busy high then low by the sample tick, no state change beyond START.
REQ-036 rx_ready=0, frames 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun pulse at the end of frame 2; then rx_ready=1 -> handshake, rx_valid falls.
REQ-037 n_rst pulsed mid-DATA with rxd held low through release -> all outputs 0, no frame reported until rxd high then a new start.
